// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_pkg
//  Purpose  : Shared types and constants for the 4-digit FND scan controller:
//             FSM state encoding, BCD digit type, active-low segment font
//             table and the display clamp value.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package fnd_pkg;

    // Scan FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_BLANK = 2'd1;
    localparam state_t ST_SHOW  = 2'd2;

    // One packed BCD digit
    typedef logic [3:0] bcd_t;

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp held off
    localparam logic [7:0] FONT_BLANK = 8'hFF;
    localparam logic [7:0] FONT_TABLE [10] = '{
        8'hC0,  // 0
        8'hF9,  // 1
        8'hA4,  // 2
        8'hB0,  // 3
        8'h99,  // 4
        8'h92,  // 5
        8'h82,  // 6
        8'hF8,  // 7
        8'h80,  // 8
        8'h90   // 9
    };

    // Largest value representable on four decimal digits
    localparam logic [13:0] MAX_VALUE = 14'd9999;

    // Font lookup; any non-decimal code renders dark
    function automatic logic [7:0] font_of(input bcd_t d);
        logic [7:0] f;
        f = FONT_BLANK;
        if (d <= 4'd9) begin
            f = FONT_TABLE[d];
        end
        return f;
    endfunction

endpackage : fnd_pkg
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_seq
//  Purpose  : Sequential 14-bit binary to 4-digit BCD converter using the
//             shift-add-3 (double-dabble) algorithm, one bit per cycle.
//  Ports    : i_clk      - system clock (rising edge)
//             i_reset_n  - asynchronous active-low reset
//             i_start    - load i_bin and begin a conversion
//             i_abort    - cancel any conversion; result registers untouched
//             i_bin      - binary operand (expected <= 9999)
//             o_done     - high during the cycle whose closing edge loads
//                          the new result into o_bcd0..o_bcd3
//             o_bcd0..3  - result digits, ones .. thousands
//  Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import fnd_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic [13:0] i_bin,
    output logic        o_done,
    output logic [3:0]  o_bcd0,
    output logic [3:0]  o_bcd1,
    output logic [3:0]  o_bcd2,
    output logic [3:0]  o_bcd3
);

    localparam logic [3:0] LAST_ITER = 4'd13;

    logic        busy_q;
    logic [3:0]  iter_q;
    logic [13:0] bin_q;
    logic [15:0] acc_q;
    logic [15:0] bcd_q;

    logic [15:0] acc_adj;
    logic [15:0] acc_nxt;
    logic [13:0] bin_nxt;
    logic        last_iter;

    // Add 3 to every digit >= 5, then shift the next binary MSB in
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < 4; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        {acc_nxt, bin_nxt} = {acc_adj, bin_q} << 1;
    end

    assign last_iter = busy_q && (iter_q == LAST_ITER) && !i_abort;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            busy_q <= 1'b0;
            iter_q <= '0;
            bin_q  <= '0;
            acc_q  <= '0;
            bcd_q  <= '0;
        end else if (i_abort) begin
            busy_q <= 1'b0;
        end else if (i_start) begin
            busy_q <= 1'b1;
            iter_q <= '0;
            bin_q  <= i_bin;
            acc_q  <= '0;
        end else if (busy_q) begin
            acc_q  <= acc_nxt;
            bin_q  <= bin_nxt;
            iter_q <= iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
                busy_q <= 1'b0;
                bcd_q  <= acc_nxt;
            end
        end
    end

    assign o_done = last_iter;
    assign o_bcd0 = bcd_q[3:0];
    assign o_bcd1 = bcd_q[7:4];
    assign o_bcd2 = bcd_q[11:8];
    assign o_bcd3 = bcd_q[15:12];

endmodule : bin2bcd_seq
`default_nettype wire

// File: rtl/fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_controller
//  Purpose  : Time-multiplexed scan driver for a 4-digit common-anode FND.
//             Latches a binary count once per frame, converts it to BCD,
//             and lights one digit per slot after an all-dark blanking gap.
//  Ports    : i_clk        - system clock (rising edge)
//             i_reset_n    - asynchronous active-low reset
//             i_en         - scan enable; low forces the display dark
//             i_value      - binary count, clamped to 9999 when latched
//             i_lz_blank   - leading-zero blanking, latched with i_value
//             o_fnd_digit  - digit enables, active-low, bit0 = ones
//             o_fnd_font   - segments {dp,g,f,e,d,c,b,a}, active-low
//             o_frame_done - pulse on the final SHOW cycle of digit 3
//  Revision : 1.0 - initial release
// ============================================================================
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_en,
    input  logic [13:0] i_value,
    input  logic        i_lz_blank,
    output logic [3:0]  o_fnd_digit,
    output logic [7:0]  o_fnd_font,
    output logic        o_frame_done
);

    localparam int SLOT_CYCLES = CLK_HZ / SCAN_HZ;
    localparam int SHOW_CYCLES = SLOT_CYCLES - BLANK_CYCLES;
    // Counter only ever holds values below SLOT_CYCLES
    localparam int CNT_W = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             lz_pend_q;
    logic             lz_q;
    logic [3:0]       digit_q, digit_d;
    logic [7:0]       font_q, font_d;
    logic             frame_done_q, frame_done_d;

    logic             latch;
    logic [13:0]      value_clamped;
    logic             cv_done;
    logic [3:0]       bcd0, bcd1, bcd2, bcd3;
    bcd_t             sel_bcd;
    logic             lead_zero;

    // Frame latch happens on the first BLANK cycle of digit 0
    assign latch = i_en && (state_q == ST_BLANK) && (cnt_q == '0) && (idx_q == 2'd0);
    assign value_clamped = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;

    bin2bcd_seq u_bin2bcd (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_start   (latch),
        .i_abort   (!i_en),
        .i_bin     (value_clamped),
        .o_done    (cv_done),
        .o_bcd0    (bcd0),
        .o_bcd1    (bcd1),
        .o_bcd2    (bcd2),
        .o_bcd3    (bcd3)
    );

    // Scan sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!i_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            idx_d   = 2'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    idx_d   = 2'd0;
                end
            endcase
        end
    end

    // Digit selected for the upcoming cycle, and whether it is a leading zero
    always_comb begin
        sel_bcd   = bcd0;
        lead_zero = 1'b0;
        case (idx_d)
            2'd0: begin
                sel_bcd   = bcd0;
                lead_zero = 1'b0;   // ones digit is always shown
            end
            2'd1: begin
                sel_bcd   = bcd1;
                lead_zero = (bcd3 == 4'd0) && (bcd2 == 4'd0) && (bcd1 == 4'd0);
            end
            2'd2: begin
                sel_bcd   = bcd2;
                lead_zero = (bcd3 == 4'd0) && (bcd2 == 4'd0);
            end
            default: begin
                sel_bcd   = bcd3;
                lead_zero = (bcd3 == 4'd0);
            end
        endcase
    end

    // Outputs are computed from next-state so they change on the entering edge
    always_comb begin
        digit_d      = 4'b1111;
        font_d       = FONT_BLANK;
        frame_done_d = 1'b0;
        if (state_d == ST_SHOW) begin
            digit_d      = ~(4'b0001 << idx_d);
            font_d       = (lz_q && lead_zero) ? FONT_BLANK : font_of(sel_bcd);
            frame_done_d = (idx_d == 2'd3) && (cnt_d == SHOW_LAST);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            lz_pend_q    <= 1'b0;
            lz_q         <= 1'b0;
            digit_q      <= 4'b1111;
            font_q       <= FONT_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            digit_q      <= digit_d;
            font_q       <= font_d;
            frame_done_q <= frame_done_d;
            if (latch) begin
                lz_pend_q <= i_lz_blank;
            end
            // LZ flag becomes visible together with the new BCD digits
            if (cv_done) begin
                lz_q <= lz_pend_q;
            end
        end
    end

    assign o_fnd_digit  = digit_q;
    assign o_fnd_font   = font_q;
    assign o_frame_done = frame_done_q;

endmodule : fnd_scan_controller
`default_nettype wire

// File: tb/tb_fnd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_controller
//  Purpose  : Self-checking bench for fnd_scan_controller. Stimulus pushes
//             the expected lit slots (digit, font, length, preceding dark
//             gap, frame_done) into a scoreboard; a monitor pops one entry
//             whenever a digit lights up and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fnd_scan_controller;

    localparam int SHOW = 80;
    localparam int GAP  = 20;
    localparam int SLOT = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [13:0] value;
    logic        lz;
    logic [3:0]  o_fnd_digit;
    logic [7:0]  o_fnd_font;
    logic        o_frame_done;

    always #5 clk = ~clk;

    fnd_scan_controller #(
        .CLK_HZ       (1000),
        .SCAN_HZ      (10),
        .BLANK_CYCLES (20)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_en         (en),
        .i_value      (value),
        .i_lz_blank   (lz),
        .o_fnd_digit  (o_fnd_digit),
        .o_fnd_font   (o_fnd_font),
        .o_frame_done (o_frame_done)
    );

    typedef struct {
        logic [3:0] dig;
        logic [7:0] font;
        int         len;   // 0 = length not checked
        int         gap;   // 0 = gap not checked
        bit         fd;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   stray_fd = 0;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] ref_font(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            default: return 8'h90;
        endcase
    endfunction

    task automatic push_slot(input int k, input int v, input bit lzf,
                             input int len, input int gap, input bit fd);
        exp_t e;
        int   vv;
        int   p;
        vv = (v > 9999) ? 9999 : v;
        p  = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        e.dig  = 4'b1111 ^ (4'b0001 << k);
        // Leading zero: this digit and all above are zero <=> value < 10^k
        e.font = (lzf && k > 0 && vv < p) ? 8'hFF : ref_font((vv / p) % 10);
        e.len  = len;
        e.gap  = gap;
        e.fd   = fd;
        sbq.push_back(e);
    endtask

    task automatic push_frame(input int v, input bit lzf, input int gap0);
        for (int k = 0; k < 4; k++) begin
            push_slot(k, v, lzf, SHOW, (k == 0) ? gap0 : GAP, (k == 3));
        end
    endtask

    task automatic run_scn(input int v, input bit lzf);
        @(posedge clk); #2;
        value = 14'(v);
        lz    = lzf;
        push_frame(v, lzf, GAP);
        en = 1'b1;
        repeat (4 * SLOT) @(posedge clk);
        #2 en = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    // ---------------- monitor ----------------
    logic [3:0] run_dig;
    logic [7:0] run_font;
    int         run_len;
    int         run_fd;
    int         run_glitch;
    bit         in_run = 1'b0;
    exp_t       cur;
    int         dark = 0;
    bit         en_prev = 1'b0;

    always @(negedge clk) begin
        logic lit;
        lit = (o_fnd_digit != 4'hF);
        if (in_run && (!lit || o_fnd_digit != run_dig)) begin
            if (cur.len != 0) check("slot_len", run_len, cur.len);
            check("frame_done_pos", run_fd, cur.fd ? cur.len : -1);
            check("font_stable", run_glitch, 0);
            in_run = 1'b0;
        end
        if (lit && !in_run) begin
            if (sbq.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL slot_unexpected: got digit=%b font=%h, required nothing queued", o_fnd_digit, o_fnd_font);
                cur.dig = 4'hF; cur.font = 8'hFF; cur.len = 0; cur.gap = 0; cur.fd = 1'b0;
            end else begin
                cur = sbq.pop_front();
                check("slot_digit", o_fnd_digit, cur.dig);
                check("slot_font", o_fnd_font, cur.font);
                if (cur.gap != 0) check("blank_gap", dark, cur.gap);
            end
            in_run     = 1'b1;
            run_dig    = o_fnd_digit;
            run_font   = o_fnd_font;
            run_len    = 1;
            run_fd     = -1;
            run_glitch = 0;
        end else if (lit) begin
            run_len++;
            if (o_fnd_font != run_font) run_glitch++;
        end
        if (o_frame_done) begin
            if (in_run) run_fd = run_len;
            else        stray_fd++;
        end
        if (lit || !en || !en_prev) dark = 0;
        else                        dark++;
        en_prev = en;
    end

    // ---------------- stimulus ----------------
    initial begin
        int idle_bad;
        int fd_at;
        rst_n = 1'b0;
        en    = 1'b0;
        value = '0;
        lz    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digit", o_fnd_digit, 4'hF);
        check("reset_font", o_fnd_font, 8'hFF);
        check("reset_frame_done", o_frame_done, 0);
        #1 rst_n = 1'b1;

        // Idle with enable low
        idle_bad = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (o_fnd_digit != 4'hF || o_fnd_font != 8'hFF || o_frame_done) idle_bad++;
        end
        check("idle_dark", idle_bad, 0);

        // Scan order and frame_done timing
        @(posedge clk); #2;
        value = 14'd1234;
        lz    = 1'b0;
        push_frame(1234, 1'b0, GAP);
        en = 1'b1;
        fd_at = 451;
        for (int c = 1; c <= 450; c++) begin
            @(posedge clk); #1;
            if (o_frame_done) begin
                fd_at = c;
                break;
            end
        end
        check("frame_done_cycle", fd_at, 4 * SLOT);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);

        // Leading zeros and clamp
        run_scn(7, 1'b1);
        run_scn(7, 1'b0);
        run_scn(0, 1'b1);
        run_scn(16383, 1'b0);
        run_scn(10000, 1'b1);

        // Value change during SHOW of digit 2 takes effect next frame
        @(posedge clk); #2;
        value = 14'd1234;
        lz    = 1'b0;
        push_frame(1234, 1'b0, GAP);
        push_frame(5678, 1'b0, GAP);
        en = 1'b1;
        repeat (260) @(posedge clk);
        #2 value = 14'd5678;
        repeat (8 * SLOT - 260) @(posedge clk);
        #2 en = 1'b0;
        repeat (5) @(posedge clk);

        // Disable during SHOW of digit 1, then re-enable with a new value
        @(posedge clk); #2;
        value = 14'd4321;
        lz    = 1'b0;
        push_slot(0, 4321, 1'b0, SHOW, GAP, 1'b0);
        push_slot(1, 4321, 1'b0, 30, GAP, 1'b0);
        en = 1'b1;
        repeat (150) @(posedge clk);
        #2 en = 1'b0;
        @(posedge clk); #1;
        check("disable_digit", o_fnd_digit, 4'hF);
        check("disable_font", o_fnd_font, 8'hFF);
        repeat (5) @(posedge clk);
        #2;
        value = 14'd8765;
        push_frame(8765, 1'b0, GAP);
        en = 1'b1;
        repeat (4 * SLOT) @(posedge clk);
        #2 en = 1'b0;
        repeat (5) @(posedge clk);

        // Asynchronous reset during SHOW of digit 0; the enable stays high,
        // so one IDLE cycle plus a full blank precede the restarted frame
        @(posedge clk); #2;
        value = 14'd2468;
        lz    = 1'b0;
        push_slot(0, 2468, 1'b0, 29, GAP, 1'b0);
        push_frame(2468, 1'b0, GAP + 1);
        en = 1'b1;
        repeat (50) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_digit", o_fnd_digit, 4'hF);
        check("async_rst_font", o_fnd_font, 8'hFF);
        #2 rst_n = 1'b1;
        repeat (4 * SLOT) @(posedge clk);
        #2 en = 1'b0;
        repeat (5) @(posedge clk);

        // Randomised values and LZ settings
        for (int r = 0; r < 6; r++) begin
            run_scn(int'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)));
        end

        repeat (10) @(posedge clk);
        check("sb_leftover", sbq.size(), 0);
        check("stray_frame_done", stray_fd, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_fnd_scan_controller
`default_nettype wire
